// File: rtl/fir_interp2.sv
`default_nettype none
// ============================================================================
// fir_interp2 : 2x polyphase interpolating FIR, h = 1,-2,3,-4,5,-6,7,-8.
// Define FIR_INTERP2_SAT_EN to saturate outputs; otherwise they wrap.
// Revision: 1.0
// ============================================================================
module fir_interp2 #(
  parameter int IN_WIDTH  = 6,
  parameter int OUT_WIDTH = 10,
  parameter int FRAC_BITS = 0
) (
  input  logic                        clk,
  input  logic                        rst_b,
  input  logic                        en,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_WIDTH-1:0]  data_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] data_out
);

  // Working width covers the full-precision sum, the rounding offset and the output range.
  localparam int SUM_W = IN_WIDTH + 6;
  localparam int BIG_W = (OUT_WIDTH > SUM_W) ? OUT_WIDTH : SUM_W;
  localparam int EXT_W = ((BIG_W > FRAC_BITS) ? BIG_W : FRAC_BITS) + 2;

  localparam logic signed [EXT_W-1:0] c_h0   = EXT_W'(1);
  localparam logic signed [EXT_W-1:0] c_h1   = EXT_W'(-2);
  localparam logic signed [EXT_W-1:0] c_h2   = EXT_W'(3);
  localparam logic signed [EXT_W-1:0] c_h3   = EXT_W'(-4);
  localparam logic signed [EXT_W-1:0] c_h4   = EXT_W'(5);
  localparam logic signed [EXT_W-1:0] c_h5   = EXT_W'(-6);
  localparam logic signed [EXT_W-1:0] c_h6   = EXT_W'(7);
  localparam logic signed [EXT_W-1:0] c_h7   = EXT_W'(-8);
  localparam logic signed [EXT_W-1:0] c_half = EXT_W'((2 ** FRAC_BITS) / 2);
`ifdef FIR_INTERP2_SAT_EN
  localparam logic signed [EXT_W-1:0] c_max  = EXT_W'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [EXT_W-1:0] c_min  = ~c_max;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PH0  = 2'd1;
  localparam logic [1:0] S_PH1  = 2'd2;

  logic [1:0]                 r_state;
  logic signed [IN_WIDTH-1:0] r_d0, r_d1, r_d2, r_d3;
  logic signed [EXT_W-1:0]    w_in, w_d0, w_d1, w_d2, w_d3;
  logic signed [EXT_W-1:0]    w_ph0_next, w_ph1;

  assign w_in = {{(EXT_W-IN_WIDTH){data_in[IN_WIDTH-1]}}, data_in};
  assign w_d0 = {{(EXT_W-IN_WIDTH){r_d0[IN_WIDTH-1]}}, r_d0};
  assign w_d1 = {{(EXT_W-IN_WIDTH){r_d1[IN_WIDTH-1]}}, r_d1};
  assign w_d2 = {{(EXT_W-IN_WIDTH){r_d2[IN_WIDTH-1]}}, r_d2};
  assign w_d3 = {{(EXT_W-IN_WIDTH){r_d3[IN_WIDTH-1]}}, r_d3};

  // Phase 0 is taken over the line as it will look after the incoming sample shifts in.
  assign w_ph0_next = c_h0 * w_in + c_h2 * w_d0 + c_h4 * w_d1 + c_h6 * w_d2;
  assign w_ph1      = c_h1 * w_d0 + c_h3 * w_d1 + c_h5 * w_d2 + c_h7 * w_d3;

  function automatic logic signed [OUT_WIDTH-1:0] shape(input logic signed [EXT_W-1:0] s);
    logic signed [EXT_W-1:0] r;
    r = (s + c_half) >>> FRAC_BITS;
`ifdef FIR_INTERP2_SAT_EN
    if (r > c_max)
      return c_max[OUT_WIDTH-1:0];
    else if (r < c_min)
      return c_min[OUT_WIDTH-1:0];
    else
      return r[OUT_WIDTH-1:0];
`else
    return r[OUT_WIDTH-1:0];
`endif
  endfunction

  assign in_ready  = en && (r_state == S_IDLE);
  assign out_valid = (r_state == S_PH0) || (r_state == S_PH1);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state  <= S_IDLE;
      r_d0     <= '0;
      r_d1     <= '0;
      r_d2     <= '0;
      r_d3     <= '0;
      data_out <= '0;
    end else if (en) begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_d0     <= data_in;
            r_d1     <= r_d0;
            r_d2     <= r_d1;
            r_d3     <= r_d2;
            data_out <= shape(w_ph0_next);
            r_state  <= S_PH0;
          end
        end
        S_PH0: begin
          if (out_ready) begin
            data_out <= shape(w_ph1);
            r_state  <= S_PH1;
          end
        end
        S_PH1: begin
          if (out_ready)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_interp2.sv
`default_nettype none
// ============================================================================
// tb_fir_interp2 : directed + random self-checking bench for fir_interp2.
// Revision: 1.0
// ============================================================================
module tb_fir_interp2;

  localparam int IN_W  = 6;
  localparam int OUT_W = 10;
  localparam int FRAC  = 0;

  logic                     clk = 1'b0;
  logic                     rst_b;
  logic                     en;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [IN_W-1:0]   data_in;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  data_out;

  int tests = 0;
  int fails = 0;

  int coef [8] = '{1, -2, 3, -4, 5, -6, 7, -8};
  int hist [4];
  longint exp_p0, exp_p1;

  fir_interp2 #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .FRAC_BITS(FRAC)) dut (
    .clk(clk), .rst_b(rst_b), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Round half up, divide by 2^FRAC with floor, then saturate or wrap to OUT_W.
  function automatic longint ref_shape(input longint s);
    longint d, r, m;
    d = longint'(1) << FRAC;
    r = s + d / 2;
    r = (r >= 0) ? r / d : -((-r + d - 1) / d);
    m = longint'(1) << OUT_W;
`ifdef FIR_INTERP2_SAT_EN
    if (r > m / 2 - 1) r = m / 2 - 1;
    if (r < -(m / 2)) r = -(m / 2);
`else
    r = ((r % m) + m) % m;
    if (r >= m / 2) r = r - m;
`endif
    return r;
  endfunction

  function automatic void model_push(input int x);
    longint s0, s1;
    for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = x;
    s0 = 0;
    s1 = 0;
    for (int k = 0; k < 4; k++) begin
      s0 += longint'(coef[2*k]) * hist[k];
      s1 += longint'(coef[2*k+1]) * hist[k];
    end
    exp_p0 = ref_shape(s0);
    exp_p1 = ref_shape(s1);
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 4; k++) hist[k] = 0;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge with phase 0 showing.
  task automatic accept(input int x);
    check("idle_in_ready", longint'(in_ready), 1);
    check("idle_out_valid", longint'(out_valid), 0);
    in_valid  = 1'b1;
    data_in   = x[IN_W-1:0];
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    model_push(x);
    check("ph0_out_valid", longint'(out_valid), 1);
    check("ph0_in_ready", longint'(in_ready), 0);
    check("ph0_data", longint'(data_out), exp_p0);
  endtask

  task automatic step_ph0();
    out_ready = 1'b1;
    @(negedge clk);
    check("ph1_data", longint'(data_out), exp_p1);
    check("ph1_out_valid", longint'(out_valid), 1);
  endtask

  task automatic step_ph1();
    out_ready = 1'b1;
    @(negedge clk);
    check("ret_out_valid", longint'(out_valid), 0);
    check("ret_in_ready", longint'(in_ready), 1);
  endtask

  task automatic full_sample(input int x);
    accept(x);
    step_ph0();
    step_ph1();
  endtask

  task automatic impulse_run();
    full_sample(1);
    for (int i = 0; i < 7; i++) full_sample(0);
  endtask

  initial begin
    int x;
    logic signed [OUT_W-1:0] held;
    rst_b     = 1'b0;
    en        = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    data_in   = '0;
    model_clear();

    // Reset values, then idle hold after release
    #12;
    check("rst_data_out", longint'(data_out), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_in_ready", longint'(in_ready), 1);
    @(negedge clk);
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_data_out", longint'(data_out), 0);
    check("post_rst_out_valid", longint'(out_valid), 0);
    check("post_rst_in_ready", longint'(in_ready), 1);

    // Impulse response
    impulse_run();

    // Constant 31 four times: full-scale phase 1 overflows the output range
    for (int i = 0; i < 4; i++) begin
      accept(31);
      if (i == 3) check("c31_ph0_lit", longint'(data_out), 496);
      step_ph0();
`ifdef FIR_INTERP2_SAT_EN
      if (i == 3) check("c31_ph1_lit", longint'(data_out), -512);
`else
      if (i == 3) check("c31_ph1_lit", longint'(data_out), 404);
`endif
      step_ph1();
    end

    // Back-pressure in PH0 with a competing input offered
    accept(-17);
    held      = data_out;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_in   = 6'sd21;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_data", longint'(data_out), longint'(held));
      check("stall_out_valid", longint'(out_valid), 1);
      check("stall_in_ready", longint'(in_ready), 0);
    end
    in_valid = 1'b0;
    step_ph0();
    step_ph1();

    // Enable low during PH1
    accept(13);
    step_ph0();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("en_data", longint'(data_out), exp_p1);
      check("en_out_valid", longint'(out_valid), 1);
      check("en_in_ready", longint'(in_ready), 0);
    end
    en = 1'b1;
    step_ph1();
    full_sample(-5);

    // Randomized samples
    for (int i = 0; i < 24; i++) begin
      x = int'($urandom_range(0, 63)) - 32;
      full_sample(x);
    end

    // Asynchronous reset in PH0
    accept(-32);
    #2;
    rst_b = 1'b0;
    #1;
    check("mid_rst_data_out", longint'(data_out), 0);
    check("mid_rst_out_valid", longint'(out_valid), 0);
    check("mid_rst_in_ready", longint'(in_ready), 1);
    model_clear();
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    impulse_run();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
